// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int unsigned CAUSE_W   = 4;
  localparam int unsigned CAUSE_POR = 0;
  localparam int unsigned CAUSE_PLL = 1;
  localparam int unsigned CAUSE_KEY = 2;
  localparam int unsigned CAUSE_SW  = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_key_debouncer.sv
// Two-flop synchroniser plus stable-count debounce for an active-low push button.
// The output level follows the synced input only after it has differed for DEBOUNCE_CYCLES+1 samples.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             key_s1;
  logic             key_s2;
  logic [CNT_W-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1     <= 1'b1;
      key_s2     <= 1'b1;
      stable_cnt <= '0;
      pressed    <= 1'b0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      // Any sample matching the current level is a bounce and restarts the count.
      if ((~key_s2) != pressed) begin
        if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
          pressed    <= ~key_s2;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + CNT_W'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: waits for PLL lock, holds, then releases domain resets in order.
// Define RESET_SEQUENCER_CAUSE_EN to add the sticky cause register and its cause/cause_clr ports.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS     = 3,
  parameter int unsigned HOLD_CYCLES     = 32,
  parameter int unsigned STAGE_GAP       = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pll_locked,
  input  logic                   key_reset,
  input  logic                   sw_reset_req,
`ifdef RESET_SEQUENCER_CAUSE_EN
  input  logic                   cause_clr,
  output logic [CAUSE_W-1:0]     cause,
`endif
  output logic [NUM_DOMAINS-1:0] rst_n,
  output logic                   ready
);

  localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, NUM_DOMAINS * STAGE_GAP)) + 1;

  seq_state_e             state;
  logic [CNT_W-1:0]       cnt;
  logic                   lock_s1;
  logic                   lock_s2;
  logic                   key_pressed;
  logic [NUM_DOMAINS-1:0] stage_due_c;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk    (clk),
    .reset  (reset),
    .key_n  (key_reset),
    .pressed(key_pressed)
  );

  // Domains whose release point is reached on the coming RELEASE edge.
  always_comb begin
    stage_due_c = '0;
    for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
      stage_due_c[i] = (cnt + CNT_W'(1)) >= CNT_W'(i * STAGE_GAP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
      state   <= WAIT_LOCK;
      cnt     <= '0;
      rst_n   <= '0;
      ready   <= 1'b0;
    end else begin
      lock_s1 <= pll_locked;
      lock_s2 <= lock_s1;
      if (!lock_s2) begin
        state <= WAIT_LOCK;
        cnt   <= '0;
        rst_n <= '0;
        ready <= 1'b0;
      end else if ((key_pressed || sw_reset_req) && (state != WAIT_LOCK)) begin
        // Held key keeps re-entering here, pinning the hold counter at zero.
        state <= HOLD;
        cnt   <= '0;
        rst_n <= '0;
        ready <= 1'b0;
      end else begin
        case (state)
          WAIT_LOCK: begin
            state <= HOLD;
            cnt   <= '0;
          end
          HOLD: begin
            if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
              state <= RELEASE;
              cnt   <= '0;
              rst_n <= NUM_DOMAINS'(1);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RELEASE: begin
            if (&rst_n) begin
              state <= RUN;
              ready <= 1'b1;
            end else begin
              cnt   <= cnt + CNT_W'(1);
              rst_n <= rst_n | stage_due_c;
            end
          end
          RUN: begin
            state <= RUN;
          end
          default: begin
            state <= WAIT_LOCK;
            rst_n <= '0;
            ready <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef RESET_SEQUENCER_CAUSE_EN
  logic [CAUSE_W-1:0] cause_set_c;

  // Lock loss only counts once lock had been reached; a waiting sequencer is not "losing" it.
  always_comb begin
    cause_set_c            = '0;
    cause_set_c[CAUSE_PLL] = !lock_s2 && (state != WAIT_LOCK);
    cause_set_c[CAUSE_KEY] = key_pressed;
    cause_set_c[CAUSE_SW]  = sw_reset_req && (state != WAIT_LOCK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cause <= CAUSE_W'(1 << CAUSE_POR);
    end else begin
      cause <= (cause_clr ? '0 : cause) | cause_set_c;
    end
  end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a negedge monitor pops and compares.
module tb_reset_sequencer;

  localparam int unsigned N = 3;
  localparam int unsigned H = 32;
  localparam int unsigned G = 16;
  localparam int unsigned D = 8;

  logic         clk          = 1'b0;
  logic         reset        = 1'b1;
  logic         pll_locked   = 1'b0;
  logic         key_reset    = 1'b1;
  logic         sw_reset_req = 1'b0;
  logic         cause_clr    = 1'b0;
  logic [N-1:0] rst_n;
  logic         ready;
`ifdef RESET_SEQUENCER_CAUSE_EN
  logic [3:0]   cause;
`endif

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [2:0] rst_n;
    logic       ready;
    logic [3:0] cause;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  reset_sequencer #(
    .NUM_DOMAINS    (N),
    .HOLD_CYCLES    (H),
    .STAGE_GAP      (G),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .key_reset   (key_reset),
    .sw_reset_req(sw_reset_req),
`ifdef RESET_SEQUENCER_CAUSE_EN
    .cause_clr   (cause_clr),
    .cause       (cause),
`endif
    .rst_n       (rst_n),
    .ready       (ready)
  );

  always #5 clk = ~clk;

  // cyc == k during the cycle after rising edge k.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.cyc != cyc || {rst_n, ready} !== {mon_e.rst_n, mon_e.ready}) begin
        errors++;
        $display("FAIL %s cyc %0d (want %0d): rst_n=%b ready=%b, expected rst_n=%b ready=%b",
                 mon_e.name, cyc, mon_e.cyc, rst_n, ready, mon_e.rst_n, mon_e.ready);
      end
`ifdef RESET_SEQUENCER_CAUSE_EN
      checks++;
      if (cause !== mon_e.cause) begin
        errors++;
        $display("FAIL %s_cause cyc %0d: cause=%b, expected %b", mon_e.name, cyc, cause, mon_e.cause);
      end
`endif
    end
  end

  // Return at the falling edge just before rising edge k, so new inputs are sampled at edge k.
  task automatic at_edge(input int k);
    while (cyc < k - 1) @(negedge clk);
  endtask

  task automatic push_exp(input int c, input logic [2:0] r, input logic rd, input logic [3:0] ca,
                          input string nm);
    exp_t e;
    e.cyc = c; e.rst_n = r; e.ready = rd; e.cause = ca; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic clear_cause(input int k);
    at_edge(k);
    cause_clr = 1'b1;
    at_edge(k + 1);
    cause_clr = 1'b0;
  endtask

  task automatic sw_pulse(input int k);
    at_edge(k);
    sw_reset_req = 1'b1;
    at_edge(k + 1);
    sw_reset_req = 1'b0;
  endtask

  initial begin
    push_exp(2, 3'b000, 1'b0, 4'b0001, "in_reset");
    push_exp(5, 3'b000, 1'b0, 4'b0001, "after_reset");
    at_edge(4);
    reset = 1'b0;

    // Lock-driven release: HOLD from 12, stages at 44/60/76, ready at 77.
    at_edge(10);
    pll_locked = 1'b1;
    push_exp(43, 3'b000, 1'b0, 4'b0001, "hold_end");
    push_exp(44, 3'b001, 1'b0, 4'b0001, "stage0");
    push_exp(59, 3'b001, 1'b0, 4'b0001, "pre_stage1");
    push_exp(60, 3'b011, 1'b0, 4'b0001, "stage1");
    push_exp(75, 3'b011, 1'b0, 4'b0001, "pre_stage2");
    push_exp(76, 3'b111, 1'b0, 4'b0001, "stage2");
    push_exp(77, 3'b111, 1'b1, 4'b0001, "ready");

    // Lock loss in RUN, then relock.
    at_edge(100);
    pll_locked = 1'b0;
    push_exp(101, 3'b111, 1'b1, 4'b0001, "loss_sync_delay");
    push_exp(102, 3'b000, 1'b0, 4'b0011, "lock_loss");
    at_edge(110);
    pll_locked = 1'b1;
    push_exp(143, 3'b000, 1'b0, 4'b0011, "relock_hold");
    push_exp(144, 3'b001, 1'b0, 4'b0011, "relock_stage0");
    push_exp(176, 3'b111, 1'b0, 4'b0011, "relock_stage2");
    push_exp(177, 3'b111, 1'b1, 4'b0011, "relock_ready");
    push_exp(180, 3'b111, 1'b1, 4'b0000, "cause_clr");
    push_exp(181, 3'b111, 1'b1, 4'b0000, "cause_clr_hold");
    clear_cause(180);

    // Key: short glitch ignored, long press restarts HOLD after debounced release.
    at_edge(190);
    key_reset = 1'b0;
    push_exp(200, 3'b111, 1'b1, 4'b0000, "key_glitch");
    at_edge(195);
    key_reset = 1'b1;
    at_edge(210);
    key_reset = 1'b0;
    push_exp(220, 3'b111, 1'b1, 4'b0000, "key_pre_press");
    push_exp(221, 3'b000, 1'b0, 4'b0100, "key_press");
    at_edge(230);
    key_reset = 1'b1;
    push_exp(239, 3'b000, 1'b0, 4'b0100, "key_held");
    push_exp(271, 3'b000, 1'b0, 4'b0100, "key_hold_end");
    push_exp(272, 3'b001, 1'b0, 4'b0100, "key_stage0");
    push_exp(279, 3'b001, 1'b0, 4'b0100, "pre_sw");

    // Software request mid-RELEASE.
    push_exp(280, 3'b000, 1'b0, 4'b1100, "sw_req");
    push_exp(311, 3'b000, 1'b0, 4'b1100, "sw_hold_end");
    push_exp(312, 3'b001, 1'b0, 4'b1100, "sw_stage0");
    push_exp(344, 3'b111, 1'b0, 4'b1100, "sw_stage2");
    push_exp(345, 3'b111, 1'b1, 4'b1100, "sw_ready");
    sw_pulse(280);

    // Simultaneous lock loss and software request; software ignored in WAIT_LOCK.
    push_exp(350, 3'b111, 1'b1, 4'b0000, "clr_run");
    clear_cause(350);
    at_edge(360);
    pll_locked = 1'b0;
    push_exp(361, 3'b111, 1'b1, 4'b0000, "simul_pre");
    push_exp(362, 3'b000, 1'b0, 4'b1010, "simul_events");
    sw_pulse(362);
    push_exp(370, 3'b000, 1'b0, 4'b0000, "clr_wait_lock");
    clear_cause(370);
    push_exp(376, 3'b000, 1'b0, 4'b0000, "sw_in_wait_lock");
    sw_pulse(375);
    at_edge(380);
    pll_locked = 1'b1;
    push_exp(413, 3'b000, 1'b0, 4'b0000, "relock2_hold");
    push_exp(414, 3'b001, 1'b0, 4'b0000, "relock2_stage0");
    push_exp(446, 3'b111, 1'b0, 4'b0000, "relock2_stage2");
    push_exp(447, 3'b111, 1'b1, 4'b0000, "relock2_ready");
    push_exp(459, 3'b111, 1'b1, 4'b0000, "pre_master");

    // Master reset mid-RUN with lock held high.
    push_exp(460, 3'b000, 1'b0, 4'b0001, "master_reset");
    at_edge(460);
    reset = 1'b1;
    at_edge(461);
    reset = 1'b0;
    push_exp(494, 3'b000, 1'b0, 4'b0001, "mr_hold_end");
    push_exp(495, 3'b001, 1'b0, 4'b0001, "mr_stage0");
    push_exp(511, 3'b011, 1'b0, 4'b0001, "mr_stage1");
    push_exp(527, 3'b111, 1'b0, 4'b0001, "mr_stage2");
    push_exp(528, 3'b111, 1'b1, 4'b0001, "mr_ready");

    at_edge(540);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
